i2c_master_arbiter: RTL and testbench

//  Shares one i2c_master_top among N requesters (EEPROM test, sensor config, ...).

---
 rtl/i2c_arb_pkg.sv | 22 ++
 rtl/i2c_master_arbiter_if.sv | 46 ++++
 rtl/i2c_rr_arbiter.sv | 33 +++
 rtl/i2c_master_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the i2c master arbiter.
// State encoding, transaction type and a width helper.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_HOLD
  } state_e;

  localparam logic TXN_RD = 1'b0;
  localparam logic TXN_WR = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester and i2c-master-side bundle of the arbiter.
// master = arbiter view, slave = requesters plus i2c master.
interface i2c_master_arbiter_if #(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]    req_rd;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ-1:0]    req_addr_2byte;
  logic [8*N_REQ-1:0]  req_dev_addr;
  logic [16*N_REQ-1:0] req_reg_addr;
  logic [8*N_REQ-1:0]  req_wdata;
  logic [N_REQ-1:0]    req_ack;
  logic [7:0]          req_rdata;
  logic                req_error;

  logic                m_read_req;
  logic                m_write_req;
  logic                m_read_ack;
  logic                m_write_ack;
  logic                m_addr_2byte;
  logic [7:0]          m_dev_addr;
  logic [15:0]         m_reg_addr;
  logic [7:0]          m_wdata;
  logic [7:0]          m_rdata;
  logic                m_error;

  modport master (
    input  req_rd, req_wr, req_addr_2byte,
    input  req_dev_addr, req_reg_addr, req_wdata,
    output req_ack, req_rdata, req_error,
    output m_read_req, m_write_req, m_addr_2byte,
    output m_dev_addr, m_reg_addr, m_wdata,
    input  m_read_ack, m_write_ack, m_rdata, m_error
  );

  modport slave (
    output req_rd, req_wr, req_addr_2byte,
    output req_dev_addr, req_reg_addr, req_wdata,
    input  req_ack, req_rdata, req_error,
    input  m_read_req, m_write_req, m_addr_2byte,
    input  m_dev_addr, m_reg_addr, m_wdata,
    output m_read_ack, m_write_ack, m_rdata, m_error
  );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr.
// Purely combinational; one-hot grant plus its index.
module i2c_rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c master between N requesters, one byte
// transaction at a time, with optional post-write hold-off.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int WR_HOLDOFF = 250000,
  localparam int IW         = clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_master_arbiter_if.master bus,
  output logic [IW-1:0]        grant_idx,
  output logic                 busy
);

  localparam int CW = clog2(WR_HOLDOFF + 1);
  localparam bit HAS_HOLD = WR_HOLDOFF > 0;
  localparam logic [CW-1:0] HOLD_LOAD =
    HAS_HOLD ? CW'(WR_HOLDOFF - 1) : '0;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              txn_q, txn_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              a2_q, a2_d;
  logic [7:0]        dev_q, dev_d;
  logic [15:0]       reg_q, reg_d;
  logic [7:0]        wd_q, wd_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [N_REQ-1:0]  gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_vld;

  logic              sel_wr;
  logic              sel_a2;
  logic [7:0]        sel_dev;
  logic [15:0]       sel_reg;
  logic [7:0]        sel_wd;

  i2c_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req (bus.req_rd | bus.req_wr),
    .ptr (ptr_q),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  // One-hot AND-OR field mux; write wins on a dual request
  always_comb begin
    sel_wr  = 1'b0;
    sel_a2  = 1'b0;
    sel_dev = '0;
    sel_reg = '0;
    sel_wd  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_wr  = bus.req_wr[i];
        sel_a2  = bus.req_addr_2byte[i];
        sel_dev = bus.req_dev_addr[8*i +: 8];
        sel_reg = bus.req_reg_addr[16*i +: 16];
        sel_wd  = bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    txn_d    = txn_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    a2_d     = a2_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ack_d    = '0;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          idx_d   = gnt_idx;
          ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ?
                    '0 : gnt_idx + 1'b1;
          txn_d   = sel_wr ? TXN_WR : TXN_RD;
          a2_d    = sel_a2;
          dev_d   = sel_dev;
          reg_d   = sel_reg;
          wd_d    = sel_wd;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (txn_q == TXN_WR) begin
          if (wr_req_q && bus.m_write_ack) begin
            wr_req_d     = 1'b0;
            err_d        = bus.m_error;
            ack_d[idx_q] = 1'b1;
            state_d      = S_RESP;
          end else begin
            wr_req_d = 1'b1;
          end
        end else begin
          if (rd_req_q && bus.m_read_ack) begin
            rd_req_d     = 1'b0;
            rdata_d      = bus.m_rdata;
            err_d        = bus.m_error;
            ack_d[idx_q] = 1'b1;
            state_d      = S_RESP;
          end else begin
            rd_req_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (HAS_HOLD && txn_q == TXN_WR && !err_q) begin
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      txn_q    <= TXN_RD;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      a2_q     <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      txn_q    <= txn_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      a2_q     <= a2_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ack      = ack_q;
  assign bus.req_rdata    = rdata_q;
  assign bus.req_error    = err_q;
  assign bus.m_read_req   = rd_req_q;
  assign bus.m_write_req  = wr_req_q;
  assign bus.m_addr_2byte = a2_q;
  assign bus.m_dev_addr   = dev_q;
  assign bus.m_reg_addr   = reg_q;
  assign bus.m_wdata      = wd_q;
  assign grant_idx        = idx_q;
  assign busy             = state_q != S_IDLE;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with an
// expectation queue and a scripted i2c master.
module tb_i2c_master_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] grant_idx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic        wr;
    logic        a2;
    logic [7:0]  dev;
    logic [15:0] ra;
    logic [7:0]  wd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_rdata = 8'h00;

  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.N_REQ(2)) bus();

  i2c_master_arbiter #(
    .N_REQ      (2),
    .WR_HOLDOFF (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input int i,
                       input logic rd, input logic wr,
                       input logic a2, input logic [7:0] dev,
                       input logic [15:0] ra,
                       input logic [7:0] wd);
    bus.req_rd[i]            = rd;
    bus.req_wr[i]            = wr;
    bus.req_addr_2byte[i]    = a2;
    bus.req_dev_addr[8*i+:8] = dev;
    bus.req_reg_addr[16*i+:16] = ra;
    bus.req_wdata[8*i+:8]    = wd;
  endtask

  task automatic push(input int i, input logic wr,
                      input logic a2, input logic [7:0] dev,
                      input logic [15:0] ra,
                      input logic [7:0] wd);
    exp_t e;
    e.idx = i; e.wr = wr; e.a2 = a2;
    e.dev = dev; e.ra = ra; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rdata = 8'h00;
  endtask

  // Plays the i2c master for the oldest expected transaction
  task automatic serve(input string tag,
                       input logic [7:0] rd,
                       input logic er,
                       output int lat);
    exp_t e;
    logic hit;
    logic [1:0] oh;
    e   = sb.pop_front();
    lat = 0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      lat++;
      hit = bus.m_read_req | bus.m_write_req;
    end
    if (!hit) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_ovl"}, 32'(bus.m_read_req & bus.m_write_req), 0);
    chk({tag, "_type"}, 32'(bus.m_write_req), 32'(e.wr));
    chk({tag, "_gnt"}, 32'(grant_idx), 32'(e.idx));
    chk({tag, "_dev"}, 32'(bus.m_dev_addr), 32'(e.dev));
    chk({tag, "_reg"}, 32'(bus.m_reg_addr), 32'(e.ra));
    chk({tag, "_a2"}, 32'(bus.m_addr_2byte), 32'(e.a2));
    if (e.wr) chk({tag, "_wd"}, 32'(bus.m_wdata), 32'(e.wd));
    // wrong-type ack must be ignored
    if (e.wr) bus.m_read_ack = 1'b1;
    else      bus.m_write_ack = 1'b1;
    @(negedge clk);
    bus.m_read_ack  = 1'b0;
    bus.m_write_ack = 1'b0;
    chk({tag, "_ign"}, 32'(bus.m_read_req | bus.m_write_req), 1);
    chk({tag, "_early"}, 32'(bus.req_ack), 0);
    if (e.wr) bus.m_write_ack = 1'b1;
    else      bus.m_read_ack = 1'b1;
    bus.m_rdata = rd;
    bus.m_error = er;
    @(negedge clk);
    bus.m_read_ack  = 1'b0;
    bus.m_write_ack = 1'b0;
    bus.m_error     = 1'b0;
    oh = 2'b00;
    oh[e.idx] = 1'b1;
    if (!e.wr) last_rdata = rd;
    chk({tag, "_ack"}, 32'(bus.req_ack), 32'(oh));
    chk({tag, "_rdata"}, 32'(bus.req_rdata), 32'(last_rdata));
    chk({tag, "_err"}, 32'(bus.req_error), 32'(er));
    chk({tag, "_clr"}, 32'(bus.m_read_req | bus.m_write_req), 0);
    if (e.wr) bus.req_wr[e.idx] = 1'b0;
    else      bus.req_rd[e.idx] = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.req_ack), 0);
  endtask

  task automatic hold_len(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int n;
    logic hit;
    bus.req_rd = '0;
    bus.req_wr = '0;
    bus.req_addr_2byte = '0;
    bus.req_dev_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata = '0;
    bus.m_read_ack = 1'b0;
    bus.m_write_ack = 1'b0;
    bus.m_rdata = '0;
    bus.m_error = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.req_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rreq", 32'(bus.m_read_req), 0);
    chk("rst_wreq", 32'(bus.m_write_req), 0);
    chk("rst_gnt", 32'(grant_idx), 0);
    chk("rst_dev", 32'(bus.m_dev_addr), 0);
    chk("rst_rdata", 32'(bus.req_rdata), 0);
    rst = 1'b0;

    // single read from requester 0
    drive(0, 1, 0, 0, 8'hA0, 16'h0010, 8'h00);
    push(0, 0, 0, 8'hA0, 16'h0010, 8'h00);
    serve("rd0", 8'h5A, 1'b0, lat);
    chk("rd0_lat", 32'(lat), 2);

    // write 0 and read 1 together, ptr at 0
    do_reset();
    drive(0, 0, 1, 0, 8'hA0, 16'h0020, 8'h33);
    drive(1, 1, 0, 0, 8'h90, 16'h0040, 8'h00);
    push(0, 1, 0, 8'hA0, 16'h0020, 8'h33);
    push(1, 0, 0, 8'h90, 16'h0040, 8'h00);
    serve("wr0", 8'hEE, 1'b0, lat);
    hold_len(n);
    chk("wr0_hold", 32'(n), 100);
    serve("rd1", 8'hC3, 1'b0, lat);
    chk("rd1_lat", 32'(lat), 2);
    hold_len(n);
    chk("rd1_nohold", 32'(n), 0);

    // dual request on 1: NACKed write first, then read
    drive(1, 1, 1, 0, 8'h52, 16'h0007, 8'h99);
    push(1, 1, 0, 8'h52, 16'h0007, 8'h99);
    push(1, 0, 0, 8'h52, 16'h0007, 8'h99);
    serve("nack", 8'h11, 1'b1, lat);
    hold_len(n);
    chk("nack_nohold", 32'(n), 0);
    serve("dual_rd", 8'h77, 1'b0, lat);

    // both hammer reads: grants must alternate
    drive(0, 1, 0, 0, 8'hA2, 16'h0100, 8'h00);
    drive(1, 1, 0, 0, 8'h92, 16'h0200, 8'h00);
    push(0, 0, 0, 8'hA2, 16'h0100, 8'h00);
    push(1, 0, 0, 8'h92, 16'h0200, 8'h00);
    push(0, 0, 0, 8'hA2, 16'h0100, 8'h00);
    push(1, 0, 0, 8'h92, 16'h0200, 8'h00);
    for (int k = 0; k < 4; k++) begin
      serve("fair", 8'(8'h20 + k), 1'b0, lat);
      if (k < 2) bus.req_rd[k % 2] = 1'b1;
    end

    // 2-byte address, then reset mid-issue
    drive(1, 1, 0, 1, 8'h50, 16'h1234, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = bus.m_read_req;
    end
    chk("a2_req", 32'(hit), 1);
    chk("a2_reg", 32'(bus.m_reg_addr), 32'h1234);
    chk("a2_flag", 32'(bus.m_addr_2byte), 1);
    chk("a2_gnt", 32'(grant_idx), 1);
    rst = 1'b1;
    bus.req_rd = '0;
    @(negedge clk);
    chk("mrst_rreq", 32'(bus.m_read_req), 0);
    chk("mrst_reg", 32'(bus.m_reg_addr), 0);
    chk("mrst_a2", 32'(bus.m_addr_2byte), 0);
    chk("mrst_gnt", 32'(grant_idx), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_rdata", 32'(bus.req_rdata), 0);
    chk("mrst_dev", 32'(bus.m_dev_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
